// File: rtl/bit_serializer.sv
// bit_serializer: double-buffered parallel-to-serial front end; shifts WIDTH-bit words out on w, one bit per bit_en strobe.
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             bit_en,
  output logic             w,
  output logic             w_valid,
  output logic             sof,
  output logic             underrun
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d, shreg_q, shreg_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             hold_full_q, hold_full_d;
  logic             w_q, w_d, w_valid_q, w_valid_d, sof_q, sof_d, underrun_q, underrun_d;
  logic             last, load;
  // data_ready depends only on registered state and reset, never on data_valid
  assign data_ready = reset & ~hold_full_q;
  assign w          = w_q;
  assign w_valid    = w_valid_q;
  assign sof        = sof_q;
  assign underrun   = underrun_q;
  assign last       = (cnt_q == LAST);
  assign load       = bit_en & hold_full_q & ((state_q == IDLE) | last);
  assign shifted    = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    w_d         = w_q;
    w_valid_d   = w_valid_q;
    sof_d       = sof_q;
    underrun_d  = underrun_q;
    if (data_valid && !hold_full_q) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
    if (bit_en) begin
      underrun_d = 1'b0;
      if (load) begin
        state_d     = SHIFT;
        shreg_d     = hold_q;
        hold_full_d = 1'b0;
        cnt_d       = '0;
        w_d         = MSB_FIRST ? hold_q[WIDTH-1] : hold_q[0];
        w_valid_d   = 1'b1;
        sof_d       = 1'b1;
      end else if (state_q == SHIFT && !last) begin
        shreg_d = shifted;
        cnt_d   = cnt_q + 1'b1;
        w_d     = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
        sof_d   = 1'b0;
      end else if (state_q == SHIFT) begin
        state_d    = IDLE;
        w_d        = IDLE_BIT;
        w_valid_d  = 1'b0;
        sof_d      = 1'b0;
        underrun_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      w_q         <= IDLE_BIT;
      w_valid_q   <= 1'b0;
      sof_q       <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      w_valid_q   <= w_valid_d;
      sof_q       <= sof_d;
      underrun_q  <= underrun_d;
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench; an MSB-first and an LSB-first instance share stimulus, each checked cycle by cycle.
module tb_bit_serializer;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         data_valid = 1'b0;
  logic         bit_en = 1'b0;
  logic [W-1:0] data_in = '0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           en_period = 1;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  initial begin
    int c;
    c = 0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      bit_en = (en_period == 1) || (c % en_period == 0);
    end
  end
  genvar g;
  for (g = 0; g < 2; g++) begin : u
    logic         w, w_valid, sof, underrun, data_ready;
    logic [W-1:0] q[$];
    logic [W-1:0] cur = '0;
    logic [W-1:0] pdat = '0;
    int           idx = -1;
    logic         ew = 1'b0, ewv = 1'b0, esof = 1'b0, eund = 1'b0, pen = 1'b0, pacc = 1'b0;
    bit_serializer #(.WIDTH(W), .MSB_FIRST(g == 0), .IDLE_BIT(1'b0)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready), .bit_en(bit_en), .w(w), .w_valid(w_valid),
      .sof(sof), .underrun(underrun)
    );
    function automatic logic bit_at(input logic [W-1:0] d, input int i);
      return (g == 0) ? d[W-1-i] : d[i];
    endfunction
    always @(negedge clk) begin
      if (!reset) begin
        q.delete();
        idx  = -1;
        ew   = 1'b0;
        ewv  = 1'b0;
        esof = 1'b0;
        eund = 1'b0;
        pen  = 1'b0;
        pacc = 1'b0;
        chk($sformatf("u%0d.rst_w", g), w, 0);
        chk($sformatf("u%0d.rst_w_valid", g), w_valid, 0);
        chk($sformatf("u%0d.rst_sof", g), sof, 0);
        chk($sformatf("u%0d.rst_underrun", g), underrun, 0);
        chk($sformatf("u%0d.rst_ready", g), data_ready, 0);
      end else begin
        if (pen) begin
          if (idx >= 0 && idx < W - 1) begin
            idx++;
            ew   = bit_at(cur, idx);
            esof = 1'b0;
            eund = 1'b0;
          end else if (q.size() > 0) begin
            cur  = q.pop_front();
            idx  = 0;
            ew   = bit_at(cur, 0);
            ewv  = 1'b1;
            esof = 1'b1;
            eund = 1'b0;
          end else begin
            eund = (idx == W - 1);
            idx  = -1;
            ew   = 1'b0;
            ewv  = 1'b0;
            esof = 1'b0;
          end
        end
        if (pacc) q.push_back(pdat);
        chk($sformatf("u%0d.w", g), w, ew);
        chk($sformatf("u%0d.w_valid", g), w_valid, ewv);
        chk($sformatf("u%0d.sof", g), sof, esof);
        chk($sformatf("u%0d.underrun", g), underrun, eund);
        chk($sformatf("u%0d.data_ready", g), data_ready, q.size() == 0);
        pen  = bit_en;
        pacc = data_valid & data_ready;
        pdat = data_in;
      end
    end
  end
  task automatic send(input logic [W-1:0] d);
    int t;
    t = 0;
    data_in    = d;
    data_valid = 1'b1;
    while (!u[0].data_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("send_timeout", t >= 200, 0);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    data_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(10);
    send(8'hF0);
    idle(15);
    send(8'hF0);
    send(8'h0F);
    idle(20);
    en_period = 3;
    send(8'hA5);
    idle(40);
    en_period = 1;
    idle(3);
    send(8'h3C);
    send(8'h96);
    send(8'hE1);
    idle(40);
    send(8'hC3);
    idle(4);
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(2);
    send(8'h5A);
    idle(15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
